instr_sequencer: RTL and testbench

//  Multi-cycle sequencer that drives the RV32 datapath through IDLE/FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/instr_sequencer_pkg.sv | 43 ++++
 rtl/instr_sequencer_timeout_ctr.sv | 32 +++
 rtl/instr_sequencer.sv | 160 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// Shared opcode constants, sequencer state/fault encodings and small helpers.
// Pure declarations: no latency, no backpressure.
package instr_sequencer_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_FAULT  = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        FC_NONE         = 2'd0,
        FC_IMEM_TIMEOUT = 2'd1,
        FC_ILLEGAL_OP   = 2'd2,
        FC_DMEM_TIMEOUT = 2'd3
    } fault_code_t;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
            default:                    return 1'b0;
        endcase
    endfunction

    // A zero limit means "no timeout", but the counter still needs one bit.
    function automatic int unsigned timeout_ctr_w(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/instr_sequencer_timeout_ctr.sv
// Memory-wait counter: cleared when not waiting, counts waiting cycles, saturates at LIMIT.
// o_expired is a registered compare (0 latency to the FSM); no backpressure.
module instr_sequencer_timeout_ctr
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned LIMIT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int unsigned W = timeout_ctr_w(LIMIT);
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LIM)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_expired = (LIMIT != 0) && (r_cnt == LIM);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle RV32 control sequencer IDLE/FETCH/DECODE/EXEC/MEM/WB with sticky fault and retire counter.
// 3-5 states per instruction at zero wait; imem/dmem ready low holds the request until ready or timeout.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT  = 15,
    parameter int unsigned RETIRE_CNT_W = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_run,
    input  logic [6:0]              i_opcode,
    input  logic                    i_reg_write,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic                    i_branch_eq,
    input  logic                    i_jmp,
    input  logic                    i_imem_ready,
    input  logic                    i_dmem_ready,
    output logic                    o_imem_req,
    output logic                    o_ir_we,
    output logic                    o_dmem_req,
    output logic                    o_dmem_we,
    output logic                    o_rf_we,
    output logic                    o_pc_we,
    output logic                    o_retire,
    output logic [RETIRE_CNT_W-1:0] o_retire_cnt,
    output logic                    o_busy,
    output logic                    o_fault,
    output logic [1:0]              o_fault_code
);

    seq_state_t               r_state;
    seq_state_t               w_state_nxt;
    fault_code_t              r_fault_code;
    fault_code_t              w_fault_code_nxt;
    logic [RETIRE_CNT_W-1:0]  r_retire_cnt;
    logic                     w_retire;
    logic                     w_mem_wait;
    logic                     w_expired;

    // Branch outcome is resolved in the datapath; the sequencer only needs
    // to know that a non-writing, non-memory instruction finishes in EXEC.
    logic w_unused_decode;
    assign w_unused_decode = i_branch_eq;

    instr_sequencer_timeout_ctr #(
        .LIMIT (MEM_TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (!w_mem_wait),
        .i_en      (w_mem_wait),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt      = r_state;
        w_fault_code_nxt = r_fault_code;
        w_retire         = 1'b0;
        w_mem_wait       = 1'b0;
        o_imem_req       = 1'b0;
        o_ir_we          = 1'b0;
        o_dmem_req       = 1'b0;
        o_dmem_we        = 1'b0;
        o_rf_we          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ready) begin
                    o_ir_we     = 1'b1;
                    w_state_nxt = ST_DECODE;
                end else begin
                    w_mem_wait = 1'b1;
                    if (w_expired) begin
                        w_state_nxt      = ST_FAULT;
                        w_fault_code_nxt = FC_IMEM_TIMEOUT;
                    end
                end
            end
            ST_DECODE: begin
                if (is_legal_opcode(i_opcode)) begin
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt      = ST_FAULT;
                    w_fault_code_nxt = FC_ILLEGAL_OP;
                end
            end
            ST_EXEC: begin
                if (i_mem_read || i_mem_write) begin
                    w_state_nxt = ST_MEM;
                end else if (i_reg_write || i_jmp) begin
                    w_state_nxt = ST_WB;
                end else begin
                    w_retire = 1'b1;
                end
            end
            ST_MEM: begin
                o_dmem_req = 1'b1;
                o_dmem_we  = i_mem_write;
                if (i_dmem_ready) begin
                    if (i_mem_read) begin
                        w_state_nxt = ST_WB;
                    end else begin
                        w_retire = 1'b1;
                    end
                end else begin
                    w_mem_wait = 1'b1;
                    if (w_expired) begin
                        w_state_nxt      = ST_FAULT;
                        w_fault_code_nxt = FC_DMEM_TIMEOUT;
                    end
                end
            end
            ST_WB: begin
                o_rf_we  = 1'b1;
                w_retire = 1'b1;
            end
            ST_FAULT: begin
                w_state_nxt = ST_FAULT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // run is only honoured at instruction boundaries.
        if (w_retire) begin
            w_state_nxt = i_run ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_fault_code <= FC_NONE;
            r_retire_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_fault_code <= w_fault_code_nxt;
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + RETIRE_CNT_W'(1);
            end
        end
    end

    assign o_pc_we      = w_retire;
    assign o_retire     = w_retire;
    assign o_retire_cnt = r_retire_cnt;
    assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_FAULT);
    assign o_fault      = (r_state == ST_FAULT);
    assign o_fault_code = r_fault_code;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized scoreboard bench: a phase-length model predicts ir_we, dmem completion, retire and fault events.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int CW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_run = 1'b0;
    logic [6:0]    i_opcode = '0;
    logic          i_reg_write = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic          i_branch_eq = 1'b0, i_jmp = 1'b0;
    logic          i_imem_ready = 1'b0, i_dmem_ready = 1'b0;
    logic          o_imem_req, o_ir_we, o_dmem_req, o_dmem_we, o_rf_we, o_pc_we, o_retire;
    logic [CW-1:0] o_retire_cnt;
    logic          o_busy, o_fault;
    logic [1:0]    o_fault_code;

    instr_sequencer #(.MEM_TIMEOUT(15), .RETIRE_CNT_W(CW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_run(i_run), .i_opcode(i_opcode),
        .i_reg_write(i_reg_write), .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .i_branch_eq(i_branch_eq), .i_jmp(i_jmp),
        .i_imem_ready(i_imem_ready), .i_dmem_ready(i_dmem_ready),
        .o_imem_req(o_imem_req), .o_ir_we(o_ir_we), .o_dmem_req(o_dmem_req),
        .o_dmem_we(o_dmem_we), .o_rf_we(o_rf_we), .o_pc_we(o_pc_we), .o_retire(o_retire),
        .o_retire_cnt(o_retire_cnt), .o_busy(o_busy), .o_fault(o_fault),
        .o_fault_code(o_fault_code)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          cyc;
        logic        flag;
        logic [31:0] val;
    } ev_t;

    ev_t  q_ir[$], q_dm[$], q_ret[$], q_flt[$];
    ev_t  m_e;
    int   n_checks = 0, n_errors = 0;
    int   cyc = 0;
    int   model_cnt = 0;
    logic mon_en = 1'b0;
    logic prev_fault = 1'b0;
    logic [6:0] ops [7] = '{OP_R_TYPE, OP_I_TYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};

    always @(posedge i_clk) cyc <= cyc + 1;

    // {reg_write, mem_read, mem_write, branch_eq, jmp} as a control unit would produce.
    function automatic logic [4:0] dec(input logic [6:0] op);
        case (op)
            OP_R_TYPE, OP_I_TYPE: return 5'b10000;
            OP_LOAD:              return 5'b11000;
            OP_STORE:             return 5'b00100;
            OP_BRANCH:            return 5'b00010;
            OP_JAL, OP_JALR:      return 5'b10001;
            default:              return 5'b00000;
        endcase
    endfunction

    function automatic logic rnd1();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [6:0] op, input logic im, input logic dm);
        i_opcode = op;
        {i_reg_write, i_mem_read, i_mem_write, i_branch_eq, i_jmp} = dec(op);
        i_imem_ready = im;
        i_dmem_ready = dm;
        step();
    endtask

    task automatic drive_junk(input logic im, input logic dm);
        i_opcode = 7'($urandom);
        {i_reg_write, i_mem_read, i_mem_write, i_branch_eq, i_jmp} = 5'($urandom);
        i_imem_ready = im;
        i_dmem_ready = dm;
        step();
    endtask

    // Called on the first FETCH cycle; returns on the cycle after retire.
    task automatic run_instr(input logic [6:0] op, input int wi, input int wd, input int drop_at);
        logic [4:0] d;
        int f, L, mem_k;
        bit has_mem, has_wb;
        logic im, dm;
        d       = dec(op);
        has_mem = d[3] | d[2];
        has_wb  = has_mem ? d[3] : (d[4] | d[0]);
        mem_k   = wi + 3;
        L       = wi + 3 + (has_mem ? 1 + wd : 0) + (has_wb ? 1 : 0);
        f       = cyc;
        q_ir.push_back('{f + wi, 1'b0, 32'd0});
        if (has_mem) q_dm.push_back('{f + mem_k + wd, d[2], 32'd0});
        q_ret.push_back('{f + L - 1, has_wb, 32'(model_cnt)});
        model_cnt = (model_cnt + 1) % (1 << CW);
        for (int k = 0; k < L; k++) begin
            if (drop_at >= 0 && k >= drop_at) i_run = 1'b0;
            im = (k == wi) ? 1'b1 : ((k < wi) ? 1'b0 : rnd1());
            if (has_mem && k >= mem_k && k <= mem_k + wd) dm = (k == mem_k + wd);
            else dm = rnd1();
            if (k <= wi) drive_junk(im, dm);
            else drive(op, im, dm);
        end
    endtask

    task automatic start_run();
        i_run = 1'b1;
        drive_junk(rnd1(), rnd1());
    endtask

    task automatic do_reset(input string tag);
        i_rst = 1'b1;
        i_run = 1'b0;
        drive_junk(rnd1(), rnd1());
        i_rst = 1'b0;
        model_cnt = 0;
        chk({tag, "_cnt"}, 32'(o_retire_cnt), 0);
        chk({tag, "_busy"}, 32'(o_busy), 0);
        chk({tag, "_fault"}, 32'(o_fault), 0);
        chk({tag, "_code"}, 32'(o_fault_code), 0);
        chk({tag, "_imem_req"}, 32'(o_imem_req), 0);
    endtask

    task automatic hold_fault(input int n);
        for (int k = 0; k < n; k++) drive_junk(rnd1(), rnd1());
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge i_clk) begin
        if (mon_en && !i_rst) begin
            if (o_ir_we) begin
                chk("ir_we_expected", 32'(q_ir.size() != 0), 1);
                chk("busy_in_fetch", 32'(o_busy), 1);
                if (q_ir.size() != 0) begin
                    m_e = q_ir.pop_front();
                    chk("ir_we_cycle", cyc, m_e.cyc);
                end
            end
            if (o_dmem_req && i_dmem_ready) begin
                chk("dmem_done_expected", 32'(q_dm.size() != 0), 1);
                if (q_dm.size() != 0) begin
                    m_e = q_dm.pop_front();
                    chk("dmem_done_cycle", cyc, m_e.cyc);
                    chk("dmem_we", 32'(o_dmem_we), 32'(m_e.flag));
                end
            end
            if (o_retire) begin
                chk("retire_expected", 32'(q_ret.size() != 0), 1);
                if (q_ret.size() != 0) begin
                    m_e = q_ret.pop_front();
                    chk("retire_cycle", cyc, m_e.cyc);
                    chk("rf_we", 32'(o_rf_we), 32'(m_e.flag));
                    chk("pc_we", 32'(o_pc_we), 1);
                    chk("retire_cnt", 32'(o_retire_cnt), m_e.val);
                end
            end
            if (o_pc_we || o_rf_we) chk("we_only_on_retire", 32'(o_retire), 1);
            if (o_fault && !prev_fault) begin
                chk("fault_expected", 32'(q_flt.size() != 0), 1);
                if (q_flt.size() != 0) begin
                    m_e = q_flt.pop_front();
                    chk("fault_cycle", cyc, m_e.cyc);
                    chk("fault_code", 32'(o_fault_code), m_e.val);
                end
            end
            if (o_fault) begin
                chk("fault_quiet", 32'({o_imem_req, o_ir_we, o_dmem_req, o_rf_we,
                                        o_pc_we, o_retire, o_busy}), 0);
            end else begin
                chk("fault_code_clear", 32'(o_fault_code), 0);
            end
        end
        prev_fault = o_fault;
    end

    initial begin
        int f;
        repeat (3) step();
        i_rst  = 1'b0;
        mon_en = 1'b1;
        chk("reset_busy", 32'(o_busy), 0);
        chk("reset_fault", 32'(o_fault), 0);
        chk("reset_cnt", 32'(o_retire_cnt), 0);
        chk("reset_req", 32'({o_imem_req, o_dmem_req, o_rf_we, o_pc_we}), 0);

        // R-type and stalled load, then wait-state boundaries that must not fault.
        start_run();
        run_instr(OP_R_TYPE, 0, 0, -1);
        chk("cnt_after_first", 32'(o_retire_cnt), 1);
        run_instr(OP_LOAD, 0, 3, -1);
        run_instr(OP_I_TYPE, 15, 0, -1);
        run_instr(OP_LOAD, 2, 15, -1);
        run_instr(OP_STORE, 15, 15, -1);

        for (int n = 0; n < 40; n++) begin
            run_instr(ops[$urandom_range(0, 6)],
                      ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 3), -1);
        end

        // run dropped on MEM entry of a store: store still retires, then IDLE.
        run_instr(OP_STORE, 1, 2, 4);
        chk("idle_after_drop_busy", 32'(o_busy), 0);
        drive_junk(rnd1(), rnd1());
        chk("idle_after_drop_req", 32'(o_imem_req), 0);

        // Illegal opcode.
        start_run();
        f = cyc;
        q_ir.push_back('{f, 1'b0, 32'd0});
        q_flt.push_back('{f + 2, 1'b0, 32'(FC_ILLEGAL_OP)});
        drive_junk(1'b1, rnd1());
        drive(7'b1111111, rnd1(), rnd1());
        hold_fault(20);
        chk("illegal_sticky", 32'(o_fault), 1);
        do_reset("rst_after_illegal");

        // Instruction memory never ready.
        start_run();
        f = cyc;
        q_flt.push_back('{f + 16, 1'b0, 32'(FC_IMEM_TIMEOUT)});
        for (int k = 0; k < 16; k++) drive_junk(1'b0, rnd1());
        hold_fault(20);
        do_reset("rst_after_imem_to");

        // Data memory never ready on a load.
        start_run();
        f = cyc;
        q_ir.push_back('{f, 1'b0, 32'd0});
        q_flt.push_back('{f + 3 + 16, 1'b0, 32'(FC_DMEM_TIMEOUT)});
        drive_junk(1'b1, rnd1());
        drive(OP_LOAD, rnd1(), rnd1());
        drive(OP_LOAD, rnd1(), rnd1());
        for (int k = 0; k < 16; k++) drive(OP_LOAD, rnd1(), 1'b0);
        hold_fault(20);
        do_reset("rst_after_dmem_to");

        // 17 back-to-back branches wrap the 4-bit counter to 1.
        start_run();
        for (int n = 0; n < 17; n++) run_instr(OP_BRANCH, 0, 0, -1);
        chk("cnt_wrap", 32'(o_retire_cnt), 1);

        // Reset while an R-type sits in EXEC.
        f = cyc;
        q_ir.push_back('{f, 1'b0, 32'd0});
        drive_junk(1'b1, rnd1());
        drive(OP_R_TYPE, rnd1(), rnd1());
        do_reset("rst_mid_exec");

        repeat (3) drive_junk(rnd1(), rnd1());
        chk("q_ir_drained", q_ir.size(), 0);
        chk("q_dm_drained", q_dm.size(), 0);
        chk("q_ret_drained", q_ret.size(), 0);
        chk("q_flt_drained", q_flt.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
